// File: rtl/tnn_pkg.sv
// Shared definitions for the ternary-neuron popcount sequencer.
package tnn_pkg;

  localparam int PC_W     = 22;
  localparam int PC_OUT_W = 5;

  localparam logic [1:0] ACT_POS  = 2'b01;
  localparam logic [1:0] ACT_NEG  = 2'b11;
  localparam logic [1:0] ACT_ZERO = 2'b00;

  typedef enum logic [1:0] {IDLE, POS, NEG, DONE} state_t;

  // Number of popcount-wide chunks needed to cover n input bits.
  function automatic int chunks(input int n);
    return (n + PC_W - 1) / PC_W;
  endfunction

endpackage

// File: rtl/tnn_chunk_sel.sv
// Combinational chunk selector: picks chunk idx of (vec & mask), zero-padding
// the bits past the end of the vector in the last chunk.
module tnn_chunk_sel
  import tnn_pkg::*;
#(
  parameter int N_IN  = 66,
  parameter int IDX_W = 2
) (
  input  logic [N_IN-1:0]  vec,
  input  logic [N_IN-1:0]  mask,
  input  logic [IDX_W-1:0] idx,
  output logic [PC_W-1:0]  chunk
);

  localparam int CHUNKS = chunks(N_IN);
  localparam int PAD_W  = CHUNKS * PC_W;

  logic [PAD_W-1:0] vec_pad;
  logic [PAD_W-1:0] mask_pad;

  // Zero-extend to a whole number of chunks, then slice the selected chunk.
  always_comb begin
    vec_pad  = PAD_W'(vec);
    mask_pad = PAD_W'(mask);
    chunk    = '0;
    if (int'(idx) < CHUNKS)
      chunk = vec_pad[int'(idx)*PC_W +: PC_W] & mask_pad[int'(idx)*PC_W +: PC_W];
  end

endmodule

// File: rtl/tnn_popcount_sched.sv
// Ternary neuron sequencer: time-multiplexes an external 22-input popcount over
// the positive then negative weight chunks, accumulates the signed net sum and
// thresholds it to a ternary activation.
module tnn_popcount_sched
  import tnn_pkg::*;
#(
  parameter int N_IN  = 66,
  parameter int TH_W  = 8,
  parameter int ACC_W = $clog2(31 * chunks(N_IN) + 1) + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N_IN-1:0]         in_x,
  input  logic [N_IN-1:0]         in_wpos,
  input  logic [N_IN-1:0]         in_wneg,
  input  logic [TH_W-1:0]         in_th,
  output logic [PC_W-1:0]         pc_a,
  input  logic [PC_OUT_W-1:0]     pc_y,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [1:0]              out_act,
  output logic signed [ACC_W-1:0] out_sum
);

  localparam int CHUNKS = chunks(N_IN);
  localparam int IDX_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int CMP_W  = ((ACC_W > TH_W) ? ACC_W : TH_W) + 2;

  state_t                   state, state_next;
  logic [IDX_W-1:0]         idx;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  pc_ext;
  logic [N_IN-1:0]          x_r, wpos_r, wneg_r;
  logic [TH_W-1:0]          th_r;
  logic [N_IN-1:0]          sel_mask;
  logic [PC_W-1:0]          chunk;
  logic                     last, accept;

  // Threshold compare at a width that holds both the sum and -T without wrap.
  function automatic logic [1:0] ternary(input logic signed [ACC_W-1:0] a,
                                         input logic [TH_W-1:0] t);
    logic signed [CMP_W-1:0] ac;
    logic signed [CMP_W-1:0] tc;
    ac = CMP_W'(a);
    tc = CMP_W'(t);
    if (ac > tc)       return ACT_POS;
    else if (ac < -tc) return ACT_NEG;
    else               return ACT_ZERO;
  endfunction

  assign sel_mask = (state == NEG) ? wneg_r : wpos_r;
  assign last     = (idx == IDX_W'(CHUNKS - 1));
  assign accept   = (state == IDLE) && in_ready && in_valid;
  assign pc_ext   = ACC_W'(pc_y);

  tnn_chunk_sel #(.N_IN(N_IN), .IDX_W(IDX_W)) u_chunk_sel (
    .vec   (x_r),
    .mask  (sel_mask),
    .idx   (idx),
    .chunk (chunk)
  );

  // Popcount operand is held at zero outside the counting passes.
  always_comb begin
    pc_a = '0;
    if (state == POS || state == NEG) pc_a = chunk;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = POS;
      POS:     if (last) state_next = NEG;
      NEG:     if (last) state_next = DONE;
      DONE:    if (out_valid && out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register; in_ready is registered so it stays low while in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      in_ready <= 1'b0;
    end else begin
      state    <= state_next;
      in_ready <= (state_next == IDLE);
    end
  end

  // Operand capture, accumulation over both passes and result hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_r       <= '0;
      wpos_r    <= '0;
      wneg_r    <= '0;
      th_r      <= '0;
      idx       <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_act   <= ACT_ZERO;
      out_sum   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            x_r    <= in_x;
            wpos_r <= in_wpos;
            wneg_r <= in_wneg;
            th_r   <= in_th;
            idx    <= '0;
            acc    <= '0;
          end
        end
        POS: begin
          acc <= acc + pc_ext;
          idx <= last ? '0 : idx + IDX_W'(1);
        end
        NEG: begin
          acc <= acc - pc_ext;
          idx <= last ? '0 : idx + IDX_W'(1);
        end
        DONE: begin
          if (!out_valid) begin
            out_sum   <= acc;
            out_act   <= ternary(acc, th_r);
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tnn_popcount_sched.sv
// Bench for tnn_popcount_sched: popcount model on pc_a/pc_y, scoreboard queue
// of expected results, one task per scenario.
module tb_tnn_popcount_sched;

  typedef struct packed {
    logic [7:0] sum;
    logic [1:0] act;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [65:0] in_x = '0, in_wpos = '0, in_wneg = '0;
  logic [7:0]  in_th = '0;
  logic [21:0] pc_a;
  logic [4:0]  pc_y;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [1:0]  out_act;
  logic [7:0]  out_sum;
  bit          approx = 1'b0;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  // Exact popcount, or an approximate one that overshoots when bit 21 is set.
  function automatic int pc_model(input logic [21:0] a, input bit ap);
    int c;
    c = $countones(a);
    if (ap && a[21]) c += 9;
    if (c > 31) c = 31;
    return c;
  endfunction

  assign pc_y = 5'(pc_model(pc_a, approx));

  tnn_popcount_sched #(.N_IN(66), .TH_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_wpos(in_wpos), .in_wneg(in_wneg), .in_th(in_th),
    .pc_a(pc_a), .pc_y(pc_y), .out_valid(out_valid), .out_ready(out_ready),
    .out_act(out_act), .out_sum(out_sum)
  );

  function automatic exp_t model(input logic [65:0] x, wp, wn, input logic [7:0] th);
    exp_t e;
    int s, t;
    logic [65:0] a, b;
    a = x & wp;
    b = x & wn;
    s = 0;
    for (int k = 0; k < 3; k++) begin
      s += pc_model(a[22*k +: 22], approx);
      s -= pc_model(b[22*k +: 22], approx);
    end
    t = int'(th);
    e.sum = 8'(s);
    if (s > t)       e.act = 2'b01;
    else if (s < -t) e.act = 2'b11;
    else             e.act = 2'b00;
    return e;
  endfunction

  // Push expectation, present request until accepted, then scramble inputs.
  task automatic drive_req(input logic [65:0] x, wp, wn, input logic [7:0] th);
    int n;
    sb.push_back(model(x, wp, wn, th));
    in_x = x; in_wpos = wp; in_wneg = wn; in_th = th; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    in_valid = 1'b0;
    in_x    = 66'({$urandom(), $urandom(), $urandom()});
    in_wpos = 66'({$urandom(), $urandom(), $urandom()});
    in_wneg = 66'({$urandom(), $urandom(), $urandom()});
    in_th   = 8'($urandom());
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin @(negedge clk); lat++; end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || pc_a !== '0 || out_sum !== '0 || out_act !== 2'b00) begin
      errors++;
      $display("FAIL reset_hold: rdy=%b vld=%b pc_a=%h sum=%h act=%b, required all 0", in_ready, out_valid, pc_a, out_sum, out_act);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || pc_a !== '0) begin
        errors++;
        $display("FAIL idle_after_reset cyc %0d: rdy=%b vld=%b pc_a=%h, required 1/0/0", i, in_ready, out_valid, pc_a);
      end
    end
  endtask

  task automatic test_all_pos();
    exp_t e;
    int lat;
    drive_req('1, '1, '0, 8'd10);
    checks++;
    if (pc_a !== 22'h3FFFFF) begin
      errors++;
      $display("FAIL pos_operand: pc_a=%h required 3fffff", pc_a);
    end
    wait_out(lat);
    e = sb.pop_front();
    checks++;
    if (lat !== 7) begin errors++; $display("FAIL latency: got %0d cycles required 7", lat); end
    checks++;
    if (out_sum !== e.sum || out_act !== e.act) begin
      errors++;
      $display("FAIL all_pos: sum=%0d act=%b required sum=%0d act=%b", $signed(out_sum), out_act, $signed(e.sum), e.act);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL release: vld=%b rdy=%b required 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_vectors();
    logic [65:0] tx[8], tp[8], tn[8];
    logic [7:0]  tt[8];
    exp_t e;
    int lat;
    tx[0] = '1;      tp[0] = 66'h3FF; tn[0] = 66'hFF_FFF0_0000; tt[0] = 8'd5;
    tx[1] = 66'h5;   tp[1] = 66'h1;   tn[1] = 66'h4;           tt[1] = 8'd0;
    tx[2] = 66'h1;   tp[2] = 66'h1;   tn[2] = 66'h4;           tt[2] = 8'd0;
    tx[3] = '1;      tp[3] = 66'h3FF; tn[3] = '0;              tt[3] = 8'd10;
    tx[4] = '1;      tp[4] = '0;      tn[4] = 66'h3FF;         tt[4] = 8'd10;
    tx[5] = '1;      tp[5] = '1;      tn[5] = '0;              tt[5] = 8'd255;
    tx[6] = '1;      tp[6] = 66'h3_0000_0000_0000_00F0; tn[6] = 66'h3_0000_0000_0000_00F0; tt[6] = 8'd0;
    tx[7] = '1;      tp[7] = '0;      tn[7] = '1;              tt[7] = 8'd65;
    for (int i = 0; i < 8; i++) begin
      drive_req(tx[i], tp[i], tn[i], tt[i]);
      wait_out(lat);
      e = sb.pop_front();
      checks++;
      if (out_valid !== 1'b1 || out_sum !== e.sum || out_act !== e.act) begin
        errors++;
        $display("FAIL vector %0d: vld=%b sum=%0d act=%b required 1 sum=%0d act=%b", i, out_valid, $signed(out_sum), out_act, $signed(e.sum), e.act);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_hold();
    exp_t e;
    int lat;
    logic [7:0] s0;
    logic [1:0] a0;
    out_ready = 1'b0;
    drive_req('1, 66'hFFFF, 66'hF_0000_0000, 8'd3);
    wait_out(lat);
    e = sb.pop_front();
    checks++;
    if (out_sum !== e.sum || out_act !== e.act) begin
      errors++;
      $display("FAIL hold_value: sum=%0d act=%b required sum=%0d act=%b", $signed(out_sum), out_act, $signed(e.sum), e.act);
    end
    s0 = out_sum; a0 = out_act;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_sum !== s0 || out_act !== a0 || in_ready !== 1'b0 || pc_a !== '0) begin
        errors++;
        $display("FAIL hold cyc %0d: vld=%b sum=%h act=%b rdy=%b pc_a=%h required 1 %h %b 0 0", i, out_valid, out_sum, out_act, in_ready, pc_a, s0, a0);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL hold_release: vld=%b rdy=%b required 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int lat;
    drive_req('1, 66'h3FF, '1, 8'd2);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    void'(sb.pop_back());
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || pc_a !== '0 || out_sum !== '0 || out_act !== 2'b00) begin
      errors++;
      $display("FAIL mid_reset: rdy=%b vld=%b pc_a=%h sum=%h act=%b required all 0", in_ready, out_valid, pc_a, out_sum, out_act);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: rdy=%b vld=%b required 1/0", in_ready, out_valid);
    end
    drive_req(66'h3_FFFF_0000_0000_0000, 66'h3_0000_0000_0000_0000, 66'h0_FFFF_0000_0000_0000, 8'd1);
    wait_out(lat);
    e = sb.pop_front();
    checks++;
    if (lat !== 7 || out_sum !== e.sum || out_act !== e.act) begin
      errors++;
      $display("FAIL post_reset_req: lat=%0d sum=%0d act=%b required 7 sum=%0d act=%b", lat, $signed(out_sum), out_act, $signed(e.sum), e.act);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int lat;
    for (int i = 0; i < 12; i++) begin
      approx = (i >= 8);
      if (i == 8) drive_req('1, '1, '0, 8'd10);
      else drive_req(66'({$urandom(), $urandom(), $urandom()}),
                     66'({$urandom(), $urandom(), $urandom()}),
                     66'({$urandom(), $urandom(), $urandom()}), 8'($urandom_range(0, 40)));
      wait_out(lat);
      e = sb.pop_front();
      checks++;
      if (out_valid !== 1'b1 || out_sum !== e.sum || out_act !== e.act) begin
        errors++;
        $display("FAIL b2b %0d (approx=%0d): vld=%b sum=%0d act=%b required 1 sum=%0d act=%b", i, approx, out_valid, $signed(out_sum), out_act, $signed(e.sum), e.act);
      end
      @(negedge clk);
    end
    approx = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_all_pos();
    test_vectors();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
